// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage.
// Optional forwarding outputs are enabled with the WB_FWD_EN macro.
package wb_pkg;

    localparam int unsigned DATA_W_DEF  = 32'd16;
    localparam int unsigned MEM_W_DEF   = 32'd32;
    localparam int unsigned RADDR_W_DEF = 32'd3;

    localparam int unsigned WB_REGWRITE = 32'd0;
    localparam int unsigned WB_MEMTOREG = 32'd1;

    typedef enum logic [0:0] {
        WB_NORM = 1'b0,
        WB_HI   = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back bundle plus the register-file write port.
// WB_FWD_EN adds the forwarding-unit outputs.
interface wb_stage_if #(
    parameter int unsigned DATA_W  = wb_pkg::DATA_W_DEF,
    parameter int unsigned MEM_W   = wb_pkg::MEM_W_DEF,
    parameter int unsigned RADDR_W = wb_pkg::RADDR_W_DEF
);
    logic               i_flush;
    logic [1:0]         i_wb;
    logic               i_en32;
    logic [RADDR_W-1:0] i_rdst;
    logic [DATA_W-1:0]  i_aluData;
    logic [MEM_W-1:0]   i_memData;
    logic               o_stall;
    logic               o_regWrite;
    logic [RADDR_W-1:0] o_regAddr;
    logic [DATA_W-1:0]  o_regData;
`ifdef WB_FWD_EN
    logic               o_fwdValid;
    logic [RADDR_W-1:0] o_fwdAddr;
    logic [DATA_W-1:0]  o_fwdData;
`endif

    modport master (
        output i_flush, i_wb, i_en32, i_rdst, i_aluData, i_memData,
`ifdef WB_FWD_EN
        input  o_fwdValid, o_fwdAddr, o_fwdData,
`endif
        input  o_stall, o_regWrite, o_regAddr, o_regData
    );

    modport slave (
        input  i_flush, i_wb, i_en32, i_rdst, i_aluData, i_memData,
`ifdef WB_FWD_EN
        output o_fwdValid, o_fwdAddr, o_fwdData,
`endif
        output o_stall, o_regWrite, o_regAddr, o_regData
    );
endinterface

// File: rtl/wb_buffer.sv
// MEM/WB pipeline register: captures when enabled, flush turns the
// captured entry into a bubble, synchronous reset clears every field.
module wb_buffer #(
    parameter int unsigned DATA_W  = wb_pkg::DATA_W_DEF,
    parameter int unsigned MEM_W   = wb_pkg::MEM_W_DEF,
    parameter int unsigned RADDR_W = wb_pkg::RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_en,
    input  logic               i_flush,
    input  logic [1:0]         i_wb,
    input  logic               i_en32,
    input  logic [RADDR_W-1:0] i_rdst,
    input  logic [DATA_W-1:0]  i_aluData,
    input  logic [MEM_W-1:0]   i_memData,
    output logic               o_valid,
    output logic [1:0]         o_wb,
    output logic               o_en32,
    output logic [RADDR_W-1:0] o_rdst,
    output logic [DATA_W-1:0]  o_aluData,
    output logic [MEM_W-1:0]   o_memData
);
    logic               r_valid;
    logic [1:0]         r_wb;
    logic               r_en32;
    logic [RADDR_W-1:0] r_rdst;
    logic [DATA_W-1:0]  r_aluData;
    logic [MEM_W-1:0]   r_memData;

    // Entry register; holds its contents whenever the stage is stalling.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_wb      <= 2'b00;
            r_en32    <= 1'b0;
            r_rdst    <= {RADDR_W{1'b0}};
            r_aluData <= {DATA_W{1'b0}};
            r_memData <= {MEM_W{1'b0}};
        end else if (i_en) begin
            r_valid   <= ~i_flush;
            r_wb      <= i_wb;
            r_en32    <= i_en32;
            r_rdst    <= i_rdst;
            r_aluData <= i_aluData;
            r_memData <= i_memData;
        end
    end

    assign o_valid   = r_valid;
    assign o_wb      = r_wb;
    assign o_en32    = r_en32;
    assign o_rdst    = r_rdst;
    assign o_aluData = r_aluData;
    assign o_memData = r_memData;
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects the write-back source and splits 32-bit loads
// into a low/high register-pair write. WB_FWD_EN adds forwarding outputs.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned MEM_W   = MEM_W_DEF,
    parameter int unsigned RADDR_W = RADDR_W_DEF
) (
    input  logic     clk,
    input  logic     i_reset,
    wb_stage_if.slave bus
);
    logic               w_valid;
    logic [1:0]         w_wb;
    logic               w_en32;
    logic [RADDR_W-1:0] w_rdst;
    logic [DATA_W-1:0]  w_aluData;
    logic [MEM_W-1:0]   w_memData;

    wb_state_e          r_state;
    wb_state_e          w_next;
    logic               w_stall;
    logic               w_capture;
    logic               w_pair;
    logic               w_regWrite;
    logic [RADDR_W-1:0] w_regAddr;
    logic [DATA_W-1:0]  w_regData;

    assign w_capture = ~w_stall;

    wb_buffer #(.DATA_W(DATA_W), .MEM_W(MEM_W), .RADDR_W(RADDR_W)) u_buffer (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_en      (w_capture),
        .i_flush   (bus.i_flush),
        .i_wb      (bus.i_wb),
        .i_en32    (bus.i_en32),
        .i_rdst    (bus.i_rdst),
        .i_aluData (bus.i_aluData),
        .i_memData (bus.i_memData),
        .o_valid   (w_valid),
        .o_wb      (w_wb),
        .o_en32    (w_en32),
        .o_rdst    (w_rdst),
        .o_aluData (w_aluData),
        .o_memData (w_memData)
    );

    // A valid 32-bit load into the register file needs a second (high) beat.
    assign w_pair = w_valid & w_wb[WB_REGWRITE] & w_wb[WB_MEMTOREG] & w_en32;

    // State register; reset also aborts a pending high-half write.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= WB_NORM;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and write-port muxing.
    always_comb begin
        w_next     = WB_NORM;
        w_stall    = 1'b0;
        w_regWrite = 1'b0;
        w_regAddr  = {RADDR_W{1'b0}};
        w_regData  = {DATA_W{1'b0}};
        case (r_state)
            WB_NORM: begin
                w_regWrite = w_valid & w_wb[WB_REGWRITE];
                w_regAddr  = w_rdst;
                if (w_wb[WB_MEMTOREG]) begin
                    w_regData = w_memData[DATA_W-1:0];
                end else begin
                    w_regData = w_aluData;
                end
                if (w_pair) begin
                    w_stall = 1'b1;
                    w_next  = WB_HI;
                end else begin
                    w_stall = 1'b0;
                    w_next  = WB_NORM;
                end
            end
            WB_HI: begin
                w_regWrite = 1'b1;
                w_regAddr  = w_rdst + {{(RADDR_W-1){1'b0}}, 1'b1};
                w_regData  = w_memData[MEM_W-1:DATA_W];
                w_stall    = 1'b0;
                w_next     = WB_NORM;
            end
            default: begin
                w_next = WB_NORM;
            end
        endcase
    end

    assign bus.o_stall    = w_stall;
    assign bus.o_regWrite = w_regWrite;
    assign bus.o_regAddr  = w_regAddr;
    assign bus.o_regData  = w_regData;

`ifdef WB_FWD_EN
    // Consumers must not forward the low half of an incomplete pair.
    assign bus.o_fwdValid = w_regWrite & ~w_stall;
    assign bus.o_fwdAddr  = w_regAddr;
    assign bus.o_fwdData  = w_regData;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage with a beat-queue reference model and
// directed literal checks. Define WB_FWD_EN to also check forwarding outputs.
module tb_wb_stage;
    import wb_pkg::*;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    bit    run_chk = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t q[$];

    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage dut (
        .clk     (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: every accepted entry expands into one or two write beats;
    // a new entry is only accepted once the previous entry's beats are used up.
    task automatic model_step(input logic r, input logic f, input logic [1:0] wb,
                              input logic e, input logic [2:0] rd,
                              input logic [15:0] alu, input logic [31:0] mem);
        beat_t b;
        logic  valid;
        if (r) begin
            q.delete();
            b = '{we: 1'b0, addr: 3'd0, data: 16'h0000};
            q.push_back(b);
        end else if (q.size() > 1) begin
            void'(q.pop_front());
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            valid = ~f;
            if (valid && wb == 2'b11 && e) begin
                b = '{we: 1'b1, addr: rd, data: mem[15:0]};
                q.push_back(b);
                b = '{we: 1'b1, addr: 3'((rd + 1) % 8), data: mem[31:16]};
                q.push_back(b);
            end else begin
                b.we   = valid & wb[0];
                b.addr = rd;
                b.data = wb[1] ? mem[15:0] : alu;
                q.push_back(b);
            end
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [1:0] wb,
                        input logic e, input logic [2:0] rd,
                        input logic [15:0] alu, input logic [31:0] mem);
        @(negedge clk);
        #1;
        rst           = r;
        bus.i_flush   = f;
        bus.i_wb      = wb;
        bus.i_en32    = e;
        bus.i_rdst    = rd;
        bus.i_aluData = alu;
        bus.i_memData = mem;
        model_step(r, f, wb, e, rd, alu, mem);
    endtask

    task automatic lit(input string nm, input logic we, input logic [2:0] a,
                       input logic [15:0] d, input logic s);
        @(posedge clk);
        #2;
        chk({nm, "_we"},    32'(bus.o_regWrite), 32'(we));
        chk({nm, "_addr"},  32'(bus.o_regAddr),  32'(a));
        chk({nm, "_data"},  32'(bus.o_regData),  32'(d));
        chk({nm, "_stall"}, 32'(bus.o_stall),    32'(s));
    endtask

    // Every-cycle comparison of the DUT against the model's current beat.
    always @(negedge clk) begin
        if (run_chk) begin
            if (q.size() == 0) begin
                chk("model_empty", 32'(q.size()), 32'd1);
            end else begin
                chk("cyc_we",    32'(bus.o_regWrite), 32'(q[0].we));
                chk("cyc_stall", 32'(bus.o_stall),    32'(q.size() > 1));
                chk("cyc_addr",  32'(bus.o_regAddr),  32'(q[0].addr));
                chk("cyc_data",  32'(bus.o_regData),  32'(q[0].data));
`ifdef WB_FWD_EN
                chk("cyc_fwdv",  32'(bus.o_fwdValid), 32'(q[0].we & (q.size() == 1)));
                chk("cyc_fwda",  32'(bus.o_fwdAddr),  32'(q[0].addr));
                chk("cyc_fwdd",  32'(bus.o_fwdData),  32'(q[0].data));
`endif
            end
        end
    end

    initial begin
        bus.i_flush   = 1'b0;
        bus.i_wb      = 2'b00;
        bus.i_en32    = 1'b0;
        bus.i_rdst    = 3'd0;
        bus.i_aluData = 16'h0000;
        bus.i_memData = 32'h0000_0000;

        step(1'b1, 1'b0, 2'b01, 1'b0, 3'd5, 16'h7777, 32'h1111_2222);
        lit("reset", 1'b0, 3'd0, 16'h0000, 1'b0);
        run_chk = 1'b1;

        step(1'b0, 1'b0, 2'b01, 1'b0, 3'd3, 16'h1234, 32'h0000_0000);
        lit("alu", 1'b1, 3'd3, 16'h1234, 1'b0);

        step(1'b0, 1'b0, 2'b11, 1'b0, 3'd2, 16'h0F0F, 32'hAAAA_5555);
        lit("ld16", 1'b1, 3'd2, 16'h5555, 1'b0);

        step(1'b0, 1'b0, 2'b11, 1'b1, 3'd7, 16'h0000, 32'hDEAD_BEEF);
        lit("pair_lo", 1'b1, 3'd7, 16'hBEEF, 1'b1);
`ifdef WB_FWD_EN
        chk("pair_lo_fwdv", 32'(bus.o_fwdValid), 32'd0);
`endif
        step(1'b0, 1'b1, 2'b01, 1'b0, 3'd4, 16'h4444, 32'h0000_0000);
        lit("pair_hi", 1'b1, 3'd0, 16'hDEAD, 1'b0);
`ifdef WB_FWD_EN
        chk("pair_hi_fwdv", 32'(bus.o_fwdValid), 32'd1);
        chk("pair_hi_fwda", 32'(bus.o_fwdAddr),  32'd0);
        chk("pair_hi_fwdd", 32'(bus.o_fwdData),  32'h0000_DEAD);
`endif
        step(1'b0, 1'b0, 2'b01, 1'b0, 3'd4, 16'h4444, 32'h0000_0000);
        lit("held", 1'b1, 3'd4, 16'h4444, 1'b0);

        step(1'b0, 1'b1, 2'b01, 1'b0, 3'd5, 16'h5A5A, 32'h0000_0000);
        lit("flush", 1'b0, 3'd5, 16'h5A5A, 1'b0);

        step(1'b0, 1'b0, 2'b11, 1'b1, 3'd1, 16'h0000, 32'h1234_5678);
        lit("rp_lo", 1'b1, 3'd1, 16'h5678, 1'b1);
        step(1'b0, 1'b0, 2'b01, 1'b0, 3'd6, 16'h6666, 32'h0000_0000);
        lit("rp_hi", 1'b1, 3'd2, 16'h1234, 1'b0);
        step(1'b1, 1'b0, 2'b01, 1'b0, 3'd6, 16'h6666, 32'h0000_0000);
        lit("rp_rst", 1'b0, 3'd0, 16'h0000, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 3'd6, 16'h6666, 32'h0000_0000);
        lit("rp_after", 1'b0, 3'd6, 16'h6666, 1'b0);

        step(1'b0, 1'b0, 2'b01, 1'b1, 3'd6, 16'hC0DE, 32'hFFFF_EEEE);
        lit("en32_alu", 1'b1, 3'd6, 16'hC0DE, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) == 0),
                 2'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 32'($urandom));
        end
        step(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0000, 32'h0000_0000);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
